// File: rtl/cxl_event_fifo.sv
// Cancel-event FIFO: registered show-ahead valid/ready output with a sticky overflow flag.
// Optional per-FIFO accept/drop statistics are enabled by defining CXL_FIFO_STATS_EN.
module cxl_event_fifo #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 5,
  parameter int AMT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ID_W-1:0]            in_client_id,
  input  logic [AMT_W-1:0]           in_amount,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            out_client_id,
  output logic [AMT_W-1:0]           out_amount,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
`ifdef CXL_FIFO_STATS_EN
  ,
  output logic [15:0]                accept_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [AMT_W-1:0] amt;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [PTR_W-1:0]   head_nxt;
  entry_t             head_dat_nxt;
  entry_t             out_q;
  logic               ovf_q;
  logic               do_push;
  logic               do_pop;
  logic               drop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign out_client_id = out_q.id;
  assign out_amount    = out_q.amt;

  // A full FIFO may still accept when the head leaves on the same edge.
  assign do_pop  = out_valid && out_ready;
  assign do_push = in_valid && (!full || do_pop);
  assign drop    = in_valid && full && !do_pop;

  always_comb begin
    cnt_nxt = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
      2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  // Next head comes from the incoming event when that event lands in the head slot.
  always_comb begin
    head_nxt = do_pop ? head + PTR_W'(1) : head;
    if (do_push && (head_nxt == tail)) begin
      head_dat_nxt.id  = in_client_id;
      head_dat_nxt.amt = in_amount;
    end else begin
      head_dat_nxt = mem[head_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail].id  <= in_client_id;
      mem[tail].amt <= in_amount;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_q <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      cnt_q <= cnt_nxt;
      if (drop) ovf_q <= 1'b1;
      // Output registers hold their last value once the FIFO drains.
      if (cnt_nxt != '0) out_q <= head_dat_nxt;
    end
  end

`ifdef CXL_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (do_push && accept_cnt != 16'hFFFF) accept_cnt <= accept_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)      drop_cnt   <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cxl_event_fifo.sv
// Bench for cxl_event_fifo: directed vector table, corner sequences and a randomized queue-model run.
module tb_cxl_event_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_client_id;
  logic [15:0] in_amount;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_client_id;
  logic [15:0] out_amount;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef CXL_FIFO_STATS_EN
  logic [15:0] accept_cnt;
  logic [15:0] drop_cnt;
`endif

  cxl_event_fifo #(.DEPTH(DEPTH), .ID_W(5), .AMT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_client_id(in_client_id), .in_amount(in_amount),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_client_id(out_client_id), .out_amount(out_amount),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef CXL_FIFO_STATS_EN
    , .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue of {id, amt} events.
  typedef struct { logic [4:0] id; logic [15:0] amt; } ev_t;
  ev_t         mq[$];
  logic        m_ovf;
  logic [4:0]  m_last_id;
  logic [15:0] m_last_amt;
  int          m_acc, m_drop;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_last_id = 0; m_last_amt = 0; m_acc = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] id, input logic [15:0] amt, input logic rdy);
    ev_t e;
    bit  pop;
    pop = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (mq.size() < DEPTH) begin
        e.id = id; e.amt = amt;
        mq.push_back(e);
        if (m_acc < 65535) m_acc++;
      end else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (mq.size() != 0) begin
      m_last_id = mq[0].id; m_last_amt = mq[0].amt;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".id"},    32'(out_client_id), 32'(m_last_id));
    chk({tag, ".amt"},   32'(out_amount), 32'(m_last_amt));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".full"},  32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
`ifdef CXL_FIFO_STATS_EN
    chk({tag, ".acc"},   32'(accept_cnt), 32'(m_acc));
    chk({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Drive at the falling edge, advance the model, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [4:0] id, input logic [15:0] amt, input logic rdy, input string tag);
    @(negedge clk);
    in_valid = v; in_client_id = id; in_amount = amt; out_ready = rdy;
    model_step(v, id, amt, rdy);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  id;
    logic [15:0] amt;
    logic        rdy;
    logic        ev;
    logic [4:0]  eid;
    logic [15:0] eamt;
    logic [3:0]  ecnt;
    logic        efull;
    logic        eov;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] id, input logic [15:0] amt, input logic rdy,
                     input logic ev, input logic [4:0] eid, input logic [15:0] eamt,
                     input logic [3:0] ecnt, input logic efull, input logic eov);
    vec_t t;
    t.v = v; t.id = id; t.amt = amt; t.rdy = rdy; t.ev = ev; t.eid = eid; t.eamt = eamt;
    t.ecnt = ecnt; t.efull = efull; t.eov = eov;
    tbl.push_back(t);
  endtask

  initial begin
    int rp;
    rst = 1; in_valid = 0; in_client_id = 0; in_amount = 0; out_ready = 0;
    model_reset();

    // Expected values below are hand-derived from the FIFO rules.
    add(1, 5'd5, 16'h0100, 0,  1, 5'd5, 16'h0100, 4'd1, 0, 0);   // first push visible next cycle
    add(0, 5'd0, 16'h0000, 0,  1, 5'd5, 16'h0100, 4'd1, 0, 0);   // held while stalled
    add(1, 5'd7, 16'h0700, 0,  1, 5'd5, 16'h0100, 4'd2, 0, 0);
    add(0, 5'd0, 16'h0000, 1,  1, 5'd7, 16'h0700, 4'd1, 0, 0);
    add(0, 5'd0, 16'h0000, 1,  0, 5'd7, 16'h0700, 4'd0, 0, 0);   // data held when empty
    for (int k = 1; k <= 8; k++)
      add(1, 5'(k), 16'(k * 16'h11), 0, 1, 5'd1, 16'h0011, 4'(k), k == 8, 0);
    add(1, 5'd9, 16'h0099, 0,  1, 5'd1, 16'h0011, 4'd8, 1, 1);   // dropped
    add(1, 5'd20, 16'h0140, 1, 1, 5'd2, 16'h0022, 4'd8, 1, 1);   // full push+pop
    for (int j = 1; j <= 6; j++)
      add(0, 5'd0, 16'h0000, 1, 1, 5'(j + 2), 16'((j + 2) * 16'h11), 4'(8 - j), 0, 1);
    add(0, 5'd0, 16'h0000, 1,  1, 5'd20, 16'h0140, 4'd1, 0, 1);
    add(0, 5'd0, 16'h0000, 1,  0, 5'd20, 16'h0140, 4'd0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.count", 32'(count), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.full", 32'(full), 0);
    chk("reset.valid", 32'(out_valid), 0);
    chk("reset.id", 32'(out_client_id), 0);
    chk("reset.amt", 32'(out_amount), 0);
    chk("reset.ovf", 32'(overflow), 0);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].id, tbl[i].amt, tbl[i].rdy, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tv", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.tid", i), 32'(out_client_id), 32'(tbl[i].eid));
      chk($sformatf("vec%0d.tamt", i), 32'(out_amount), 32'(tbl[i].eamt));
      chk($sformatf("vec%0d.tcnt", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d.tfull", i), 32'(full), 32'(tbl[i].efull));
      chk($sformatf("vec%0d.tovf", i), 32'(overflow), 32'(tbl[i].eov));
    end
`ifdef CXL_FIFO_STATS_EN
    chk("stats.drop_after_table", 32'(drop_cnt), 1);
`endif

    // Empty FIFO with ready asserted and nothing to pop.
    for (int i = 0; i < 5; i++) begin
      step(0, 5'd0, 16'h0, 1, "idle_rdy");
      chk("idle_rdy.nospur", 32'(out_valid), 0);
    end
    step(1, 5'd11, 16'hBEEF, 1, "push_rdy_empty");
    chk("push_rdy_empty.count", 32'(count), 1);
    step(0, 5'd0, 16'h0, 1, "drain_one");

    // Reset asserted mid-cycle with entries and a sticky overflow present.
    for (int i = 0; i < 3; i++) step(1, 5'(i + 1), 16'(i + 16'h30), 0, "prerst");
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("rst_mid.count", 32'(count), 0);
    chk("rst_mid.empty", 32'(empty), 1);
    chk("rst_mid.valid", 32'(out_valid), 0);
    chk("rst_mid.ovf", 32'(overflow), 0);
    chk("rst_mid.id", 32'(out_client_id), 0);
`ifdef CXL_FIFO_STATS_EN
    chk("rst_mid.acc", 32'(accept_cnt), 0);
    chk("rst_mid.drop", 32'(drop_cnt), 0);
`endif
    @(negedge clk);
    rst = 0;

    // Continuous stream with the consumer always ready: occupancy never exceeds one.
    for (int i = 0; i < 20; i++) begin
      step(1, 5'(i + 3), 16'(16'h1000 + i), 1, "stream");
      chk("stream.count_le1", 32'(count <= 1), 1);
    end
`ifdef CXL_FIFO_STATS_EN
    chk("stream.acc", 32'(accept_cnt), 20);
`endif
    step(0, 5'd0, 16'h0, 1, "stream_tail");

    // Randomized traffic with varying consumer throughput to reach full and drop.
    for (int blk = 0; blk < 20; blk++) begin
      rp = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < 60, 5'($urandom), 16'($urandom), $urandom_range(0, 99) < rp, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
